// File: rtl/ti_wire_master.sv
// ti_wire_master: initiator for the wire-endpoint bus; pushes a shadow wire-in bank
// (write set + update strobe) and pulls a capture wire-out bank (capture strobe + reads).
module ti_wire_master #(
   parameter int         N_IN     = 3,
   parameter int         N_OUT    = 2,
   parameter logic [7:0] IN_BASE  = 8'h00,
   parameter logic [7:0] OUT_BASE = 8'h20
) (
   input  logic        ti_clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   output logic        done,
   input  logic        sh_we,
   input  logic [4:0]  sh_idx,
   input  logic [15:0] sh_data,
   input  logic [4:0]  rd_idx,
   output logic [15:0] rd_data,
   output logic [7:0]  bus_addr,
   output logic        bus_wr,
   output logic [15:0] bus_wdata,
   output logic        bus_update,
   output logic        bus_capture,
   output logic        bus_rd,
   input  logic [15:0] bus_rdata
);
   typedef enum logic [2:0] {IDLE, WR, UPD, CAP, RD, DRAIN} state_t;
   localparam logic [4:0] LAST_IN  = 5'(N_IN - 1);
   localparam logic [4:0] LAST_OUT = 5'(N_OUT - 1);
   state_t      r_state, w_state_n;
   logic [4:0]  r_idx, w_idx_n, r_sidx;
   logic        r_samp, w_done_n;
   logic [7:0]  w_addr_n;
   logic [15:0] w_wdata_n;
   logic [15:0] r_sh [32];
   logic [15:0] r_cap [32];
   assign cmd_ready = (r_state == IDLE) && !reset;
   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_done_n  = 1'b0;
      case (r_state)
         IDLE: if (cmd_valid) begin
            w_state_n = cmd_op ? CAP : WR;
            w_idx_n   = 5'd0;
         end
         WR: begin
            w_state_n = (r_idx == LAST_IN) ? UPD : WR;
            w_idx_n   = r_idx + 5'd1;
         end
         UPD: begin
            w_state_n = IDLE;
            w_done_n  = 1'b1;
         end
         CAP: begin
            w_state_n = RD;
            w_idx_n   = 5'd0;
         end
         RD: begin
            w_state_n = (r_idx == LAST_OUT) ? DRAIN : RD;
            w_idx_n   = r_idx + 5'd1;
         end
         DRAIN: begin
            w_state_n = IDLE;
            w_done_n  = 1'b1;
         end
         default: w_state_n = IDLE;
      endcase
      w_addr_n  = (w_state_n == WR) ? IN_BASE + {3'b000, w_idx_n} :
                  (w_state_n == RD) ? OUT_BASE + {3'b000, w_idx_n} : bus_addr;
      // a shadow write landing this cycle on the word about to go out is forwarded
      w_wdata_n = (w_state_n != WR) ? bus_wdata :
                  (sh_we && sh_idx == w_idx_n) ? sh_data : r_sh[w_idx_n];
   end
   always_ff @(posedge ti_clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_idx       <= 5'd0;
         r_sidx      <= 5'd0;
         r_samp      <= 1'b0;
         done        <= 1'b0;
         bus_addr    <= 8'h00;
         bus_wdata   <= 16'h0000;
         bus_wr      <= 1'b0;
         bus_update  <= 1'b0;
         bus_capture <= 1'b0;
         bus_rd      <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_idx       <= w_idx_n;
         r_samp      <= bus_rd;
         r_sidx      <= r_idx;
         done        <= w_done_n;
         bus_addr    <= w_addr_n;
         bus_wdata   <= w_wdata_n;
         bus_wr      <= (w_state_n == WR);
         bus_update  <= (w_state_n == UPD);
         bus_capture <= (w_state_n == CAP);
         bus_rd      <= (w_state_n == RD);
      end
   end
   // words past N_IN/N_OUT are never written, so they stay zero
   always_ff @(posedge ti_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_sh[i]  <= 16'h0000;
            r_cap[i] <= 16'h0000;
         end
         rd_data <= 16'h0000;
      end else begin
         if (sh_we && ({1'b0, sh_idx} < 6'(N_IN))) r_sh[sh_idx] <= sh_data;
         if (r_samp) r_cap[r_sidx] <= bus_rdata;
         rd_data <= r_cap[rd_idx];
      end
   end
endmodule
